// File: rtl/tape_mem.sv
// Parametrised tape memory: hardware zero-fill sweep, single-cycle INC/DEC read-modify-write,
// and a registered response carrying a zero flag for loop tests.
module tape_mem #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [2:0]    i_req_op,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_rsp_valid,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_zero,
    output logic          o_busy
);

    localparam int unsigned Depth = 2 ** AW;

    localparam logic [2:0] OpRead  = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpInc   = 3'd2;
    localparam logic [2:0] OpDec   = 3'd3;
    localparam logic [2:0] OpClear = 3'd4;

    typedef enum logic {StClear, StIdle} state_e;

    state_e        r_state, w_state_next;
    logic [AW-1:0] r_clr_ptr, w_clr_ptr_next;
    logic [DW-1:0] r_mem [Depth];

    logic          w_accept;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rd_data;
    logic          w_rsp_fire;
    logic [DW-1:0] w_rsp_value;

    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_zero;

    assign o_req_ready = (r_state == StIdle);
    assign o_busy      = (r_state == StClear);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_rd_data   = r_mem[i_req_addr];

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_zero  = r_rsp_zero;

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_we           = 1'b0;
        w_waddr        = i_req_addr;
        w_wdata        = i_req_wdata;
        w_rsp_fire     = 1'b0;
        w_rsp_value    = w_rd_data;
        unique case (r_state)
            StClear: begin
                w_we           = 1'b1;
                w_waddr        = r_clr_ptr;
                w_wdata        = '0;
                // Pointer wraps to 0 on the last address, leaving it ready for the next sweep.
                w_clr_ptr_next = r_clr_ptr + AW'(1);
                if (r_clr_ptr == '1) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                if (w_accept) begin
                    case (i_req_op)
                        OpRead: begin
                            w_rsp_fire = 1'b1;
                        end
                        OpWrite: begin
                            w_we        = 1'b1;
                            w_rsp_fire  = 1'b1;
                            w_rsp_value = i_req_wdata;
                        end
                        OpInc: begin
                            w_we        = 1'b1;
                            w_wdata     = w_rd_data + DW'(1);
                            w_rsp_fire  = 1'b1;
                            w_rsp_value = w_wdata;
                        end
                        OpDec: begin
                            w_we        = 1'b1;
                            w_wdata     = w_rd_data - DW'(1);
                            w_rsp_fire  = 1'b1;
                            w_rsp_value = w_wdata;
                        end
                        OpClear: begin
                            w_state_next = StClear;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StClear;
            r_clr_ptr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clr_ptr   <= w_clr_ptr_next;
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_data <= w_rsp_value;
                r_rsp_zero <= (w_rsp_value == '0);
            end
        end
    end

    // Storage has no reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_tape_mem.sv
// Directed bench for tape_mem (AW=4, DW=8): the driver queues expected responses and a
// negedge monitor pops and compares them against the response port.
module tb_tape_mem;

    logic       clk;
    logic       rst_n;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [2:0] i_req_op;
    logic [3:0] i_req_addr;
    logic [7:0] i_req_wdata;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic       o_rsp_zero;
    logic       o_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    localparam logic [2:0] OpRead  = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpInc   = 3'd2;
    localparam logic [2:0] OpDec   = 3'd3;
    localparam logic [2:0] OpClear = 3'd4;

    tape_mem #(
        .AW(4),
        .DW(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_op   (i_req_op),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_data (o_rsp_data),
        .o_rsp_zero (o_rsp_zero),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds the request until accepted; returns the number of not-ready cycles waited.
    task automatic issue(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] wd,
                         input bit has_rsp, input logic [7:0] exp, output int waits);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_wdata = wd;
        waits       = 0;
        while (!o_req_ready && waits < 100) begin
            waits++;
            @(posedge clk);
            #1;
        end
        if (!o_req_ready) begin
            check("accept_timeout", 32'(o_req_ready), 32'd1);
        end else begin
            @(posedge clk);
            if (has_rsp) exp_q.push_back(exp);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
        check("rst_rsp_zero", 32'(o_rsp_zero), 32'd0);
    endtask

    // Call right after releasing reset on a negedge.
    task automatic count_sweep();
        int cnt;
        cnt = 0;
        while (o_busy && cnt < 100) begin
            check("sweep_ready_low", 32'(o_req_ready), 32'd0);
            cnt++;
            @(negedge clk);
        end
        check("sweep_cycles", 32'(cnt), 32'd16);
        check("ready_after_sweep", 32'(o_req_ready), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(o_rsp_valid), 32'd1);
                check("rsp_data", 32'(o_rsp_data), 32'(e));
                check("rsp_zero", 32'(o_rsp_zero), 32'(e == 8'h00));
            end else if (o_rsp_valid) begin
                check("spurious_rsp_valid", 32'(o_rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        int w;
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_req_op    = OpRead;
        i_req_addr  = '0;
        i_req_wdata = '0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep();

        for (int i = 0; i < 16; i++) issue(OpRead, 4'(i), 8'h00, 1'b1, 8'h00, w);

        issue(OpWrite, 4'd3, 8'h5A, 1'b1, 8'h5A, w);
        issue(OpRead, 4'd3, 8'h00, 1'b1, 8'h5A, w);

        issue(OpWrite, 4'd7, 8'hFF, 1'b1, 8'hFF, w);
        issue(OpInc, 4'd7, 8'h00, 1'b1, 8'h00, w);
        issue(OpDec, 4'd7, 8'h00, 1'b1, 8'hFF, w);

        issue(OpInc, 4'd2, 8'h00, 1'b1, 8'h01, w);
        issue(OpInc, 4'd2, 8'h00, 1'b1, 8'h02, w);
        issue(OpInc, 4'd2, 8'h00, 1'b1, 8'h03, w);
        issue(OpRead, 4'd2, 8'h00, 1'b1, 8'h03, w);

        // Reserved op must leave the cell untouched and produce no response.
        issue(OpWrite, 4'd9, 8'h33, 1'b1, 8'h33, w);
        issue(3'd6, 4'd9, 8'h77, 1'b0, 8'h00, w);
        issue(OpRead, 4'd9, 8'h00, 1'b1, 8'h33, w);
        idle(2);

        issue(OpWrite, 4'd0, 8'h11, 1'b1, 8'h11, w);
        issue(OpWrite, 4'd1, 8'h22, 1'b1, 8'h22, w);
        issue(OpWrite, 4'd2, 8'h80, 1'b1, 8'h80, w);
        issue(OpWrite, 4'd3, 8'h01, 1'b1, 8'h01, w);
        issue(OpClear, 4'd5, 8'hAA, 1'b0, 8'h00, w);
        check("clear_no_wait", 32'(w), 32'd0);
        issue(OpRead, 4'd0, 8'h00, 1'b1, 8'h00, w);
        check("clear_ready_low_cycles", 32'(w), 32'd16);
        for (int i = 1; i < 16; i++) issue(OpRead, 4'(i), 8'h00, 1'b1, 8'h00, w);
        idle(2);

        // Reset mid-sweep while rsp_data holds a nonzero value.
        issue(OpWrite, 4'd6, 8'h44, 1'b1, 8'h44, w);
        issue(OpClear, 4'd0, 8'h00, 1'b0, 8'h00, w);
        idle(8);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep();
        issue(OpRead, 4'd6, 8'h00, 1'b1, 8'h00, w);
        issue(OpRead, 4'd9, 8'h00, 1'b1, 8'h00, w);
        idle(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tape_mem.md
Name: tape_mem

Overview:
Parametrised data memory for the BeeF core, replacing the fixed 8-bit/256-entry data RAM.
- Adds hardware zero-fill after reset and on command, plus single-cycle read-modify-write increment/decrement of a cell.
- Adds a registered response with a zero flag for loop tests.
- Sits between the execute stage and the tape storage; the core issues one request per cycle via a valid/ready handshake.

Parameters:
AW, 8, address width; depth = 2**AW cells
DW, 8, cell data width; all arithmetic is modulo 2**DW

Ports:
clk  input  1  clock; all state changes on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present this cycle
req_ready  output  1  block can accept a request this cycle
req_op  input  3  0=READ, 1=WRITE, 2=INC, 3=DEC, 4=CLEAR, 5..7 reserved
req_addr  input  AW  cell address (ignored for CLEAR)
req_wdata  input  DW  write data (WRITE only)
rsp_valid  output  1  one-cycle pulse: response data valid
rsp_data  output  DW  resulting cell value of the accepted op
rsp_zero  output  1  rsp_data == 0; valid with rsp_valid
busy  output  1  clear sweep in progress

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values (on rst_n low, asynchronously): state=CLEAR, clr_ptr=0, busy=1, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0.
  - Array contents are not reset directly; the sweep zeroes them.
- State machine:
  - CLEAR: each cycle writes DM[clr_ptr]=0, then clr_ptr++. The cycle that writes the last address (2**AW-1) sets state=IDLE and clr_ptr=0.
  - A full sweep takes exactly 2**AW cycles. busy=1 and req_ready=0 throughout CLEAR.
  - IDLE: busy=0, req_ready=1.
- req_ready is combinational from state only (1 iff IDLE). Accept = req_valid && req_ready at the posedge.
- On accept in IDLE, by op:
  - READ: no write. Next cycle: rsp_data=DM[addr].
  - WRITE: DM[addr]<=req_wdata. Next cycle: rsp_data=req_wdata.
  - INC: DM[addr]<=DM[addr]+1, wrapping 2**DW-1 -> 0. Next cycle: rsp_data=new value.
  - DEC: DM[addr]<=DM[addr]-1, wrapping 0 -> 2**DW-1. Next cycle: rsp_data=new value.
  - CLEAR: no response. State becomes CLEAR next cycle; req_ready is low for the following 2**AW cycles.
  - Reserved ops: accepted, no memory effect, no response.
- Response timing:
  - Latency is 1 cycle: rsp_valid is registered high in the cycle after accept, for one cycle.
  - rsp_data and rsp_zero hold their last value when rsp_valid=0.
  - No backpressure on the response.
- Back-to-back: one op per cycle sustained.
  - An op to the same address in the cycle after a write/INC/DEC must see the updated value, since the array is written at the accepting edge and read combinationally in the next cycle.
  - No bypass hazards are allowed.
- Reads of the array are combinational inside the block. Writes are clocked, one write port, one read port.
- rst_n asserted mid-sweep or mid-operation: immediate return to reset values, and the sweep restarts from address 0 after release.
  - A response pending at reset is dropped.
- req_valid while not ready: ignored, no side effects. The requester holds the request until accepted.
- Address out of range cannot occur, since depth = 2**AW.

Test Plan:
- AW=4, DW=8; release rst_n -> busy=1 and req_ready=0 for exactly 16 cycles, then ready=1; READ of every address returns 0 with rsp_zero=1.
- WRITE addr 3 data 0x5A, then READ addr 3 on the next cycle -> rsp_valid pulses each cycle; rsp_data=0x5A twice, rsp_zero=0.
- WRITE addr 7 0xFF, INC addr 7 -> rsp_data=0x00, rsp_zero=1. Then DEC addr 7 -> rsp_data=0xFF, rsp_zero=0.
- INC addr 2 on three consecutive cycles from 0 -> rsp_data 1, 2, 3 on consecutive cycles; a following READ addr 2 returns 3.
- Populate addrs 0..3 nonzero, issue CLEAR -> req_ready low for 16 cycles with req_valid held high and nothing accepted; afterwards all addresses read 0.
- Assert rst_n low at sweep cycle 9 for 2 cycles -> outputs return to reset values immediately; after release, exactly 16 more busy cycles.
